// File: rtl/uart_dma_pkg.sv
// Shared response codes, loader state encoding and error-flag bit positions.
// Pure declarations: no logic, no latency, no flow control.
package uart_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3
   } state_e;

   localparam logic [7:0] RSP_OK      = 8'h00;
   localparam logic [7:0] RSP_CSUM    = 8'h01;
   localparam logic [7:0] RSP_DONE    = 8'hA5;
   localparam logic [7:0] RSP_FRAME   = 8'hFD;
   localparam logic [7:0] RSP_TIMEOUT = 8'hFE;
   localparam logic [7:0] RSP_LEN     = 8'hFF;

   localparam int ERR_LEN     = 0;
   localparam int ERR_TIMEOUT = 1;
   localparam int ERR_FRAME   = 2;
   localparam int ERR_OVERRUN = 3;

endpackage

// File: rtl/sync_byte_fifo.sv
// 8-bit synchronous FIFO; head is visible combinationally, push/pop take effect on the next edge.
// Push while full is accepted only if a pop happens in the same cycle; otherwise it is dropped.
module sync_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] push_dat_i,
   input  logic       pop_i,
   output logic [7:0] pop_dat_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [PW:0] wptr_q;
   logic [PW:0] rptr_q;
   logic        wr_en;
   logic        rd_en;

   assign empty_o   = (wptr_q == rptr_q);
   assign full_o    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign wr_en     = push_i && (!full_o || pop_i);
   assign rd_en     = pop_i && !empty_o;
   assign pop_dat_o = mem_q[rptr_q[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + {{PW{1'b0}}, 1'b1};
         if (rd_en) rptr_q <= rptr_q + {{PW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[PW-1:0]] <= push_dat_i;
   end

endmodule

// File: rtl/uart_instr_stream_loader.sv
// Loads a length-prefixed burst of XOR-checksummed instructions from UART RX into the instruction buffer.
// Write strobe and status push land one edge after the checksum byte; status bytes queue while TX stalls.
module uart_instr_stream_loader
   import uart_dma_pkg::*;
#(
   parameter int INSTR_BYTES    = 4,
   parameter int DEPTH          = 32,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int RESP_DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   input  logic                     rx_error,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic                     stream_start,
   input  logic                     stream_abort,
   output logic                     instr_wr_en,
   output logic [ADDR_W-1:0]        instr_wr_addr,
   output logic [INSTR_BYTES*8-1:0] instr_wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_W:0]          instr_count,
   output logic [3:0]               err_flags,
   output logic [2:0]               state_dbg
);

   localparam int IW     = INSTR_BYTES * 8;
   localparam int BIDX_W = $clog2(INSTR_BYTES) + 1;
   localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(INSTR_BYTES - 1);
   localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

   state_e              state_q, state_d;
   logic [ADDR_W:0]     n_q, n_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [BIDX_W-1:0]   bidx_q, bidx_d;
   logic [IW-1:0]       asm_q, asm_d;
   logic [7:0]          csum_q, csum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [IW-1:0]       wr_data_q, wr_data_d;
   logic                done_q, done_d;
   logic                pend_q, pend_d;
   logic [3:0]          err_q, err_d;

   logic                push_vld;
   logic [7:0]          push_dat;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [7:0]          fifo_head;

   assign pop = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      bidx_d    = bidx_q;
      asm_d     = asm_q;
      csum_d    = csum_q;
      tmo_d     = (state_q == ST_IDLE || rx_valid) ? '0 : tmo_q + TMO_ONE;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      pend_d    = 1'b0;
      err_d     = err_q;
      push_vld  = 1'b0;
      push_dat  = 8'h00;

      // Second half of a completion; the loader is back in IDLE so nothing else can push now.
      if (pend_q) begin
         push_vld = 1'b1;
         push_dat = RSP_DONE;
      end

      if (state_q == ST_IDLE) begin
         if (stream_start) begin
            state_d = ST_LEN;
            cnt_d   = '0;
            bidx_d  = '0;
            csum_d  = 8'h00;
         end
      end else if (stream_abort) begin
         state_d = ST_IDLE;
      end else if (rx_valid && rx_error) begin
         push_vld         = 1'b1;
         push_dat         = RSP_FRAME;
         err_d[ERR_FRAME] = 1'b1;
         state_d          = ST_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            ST_LEN: begin
               if (rx_data == 8'h00 || int'(rx_data) > DEPTH) begin
                  push_vld       = 1'b1;
                  push_dat       = RSP_LEN;
                  err_d[ERR_LEN] = 1'b1;
                  state_d        = ST_IDLE;
               end else begin
                  n_d     = rx_data[ADDR_W:0];
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               asm_d  = (asm_q << 8) | IW'(rx_data);
               csum_d = csum_q ^ rx_data;
               bidx_d = bidx_q + BIDX_ONE;
               if (bidx_q == BIDX_LAST) state_d = ST_CSUM;
            end
            ST_CSUM: begin
               bidx_d   = '0;
               csum_d   = 8'h00;
               push_vld = 1'b1;
               state_d  = ST_DATA;
               if (rx_data == csum_q) begin
                  push_dat  = RSP_OK;
                  wr_en_d   = 1'b1;
                  wr_addr_d = cnt_q[ADDR_W-1:0];
                  wr_data_d = asm_q;
                  cnt_d     = cnt_q + CNT_ONE;
                  if (cnt_q + CNT_ONE == n_q) begin
                     done_d  = 1'b1;
                     pend_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  push_dat = RSP_CSUM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo_q == TMO_LAST) begin
         push_vld           = 1'b1;
         push_dat           = RSP_TIMEOUT;
         err_d[ERR_TIMEOUT] = 1'b1;
         state_d            = ST_IDLE;
      end

      if (push_vld && fifo_full && !pop) err_d[ERR_OVERRUN] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q       <= '0;
         cnt_q     <= '0;
         bidx_q    <= '0;
         asm_q     <= '0;
         csum_q    <= 8'h00;
         tmo_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         pend_q    <= 1'b0;
         err_q     <= 4'h0;
      end else begin
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         bidx_q    <= bidx_d;
         asm_q     <= asm_d;
         csum_q    <= csum_d;
         tmo_q     <= tmo_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
      end
   end

   sync_byte_fifo #(
      .DEPTH (RESP_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push_vld),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .pop_dat_o  (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign tx_valid      = !fifo_empty;
   assign tx_data       = fifo_empty ? 8'h00 : fifo_head;
   assign instr_wr_en   = wr_en_q;
   assign instr_wr_addr = wr_addr_q;
   assign instr_wr_data = wr_data_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign instr_count   = cnt_q;
   assign err_flags     = err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_instr_stream_loader.sv
// Scenario bench for the instruction stream loader: expected responses and writes are queued
// as stimulus is driven and retired by monitors as the DUT emits them.
module tb_uart_instr_stream_loader;

   localparam int IB    = 4;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int TMO   = 200;
   localparam int RD    = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_error;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          stream_start;
   logic          stream_abort;
   logic          instr_wr_en;
   logic [AW-1:0] instr_wr_addr;
   logic [31:0]   instr_wr_data;
   logic          busy;
   logic          done;
   logic [AW:0]   instr_count;
   logic [3:0]    err_flags;
   logic [2:0]    state_dbg;

   int   checks   = 0;
   int   failures = 0;
   int   wr_cnt   = 0;
   logic [7:0] exp_rsp[$];
   wr_t        exp_wr[$];
   logic [7:0] mon_rsp;
   wr_t        mon_wr;

   always #5 clk = ~clk;

   uart_instr_stream_loader #(
      .INSTR_BYTES    (IB),
      .DEPTH          (DEPTH),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TMO),
      .RESP_DEPTH     (RD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_error      (rx_error),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .stream_start  (stream_start),
      .stream_abort  (stream_abort),
      .instr_wr_en   (instr_wr_en),
      .instr_wr_addr (instr_wr_addr),
      .instr_wr_data (instr_wr_data),
      .busy          (busy),
      .done          (done),
      .instr_count   (instr_count),
      .err_flags     (err_flags),
      .state_dbg     (state_dbg)
   );

   // Scoreboard retirement on the falling edge, clear of the active edge.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         checks++;
         if (exp_rsp.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected got=%02h required=none", tx_data);
         end else begin
            mon_rsp = exp_rsp.pop_front();
            if (tx_data !== mon_rsp) begin
               failures++;
               $display("FAIL rsp_value got=%02h required=%02h", tx_data, mon_rsp);
            end
         end
      end
      if (!rst && instr_wr_en) begin
         wr_cnt++;
         checks++;
         if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected got=%0d:%08h required=none", instr_wr_addr, instr_wr_data);
         end else begin
            mon_wr = exp_wr.pop_front();
            if (instr_wr_addr !== mon_wr.addr || instr_wr_data !== mon_wr.data) begin
               failures++;
               $display("FAIL wr_value got=%0d:%08h required=%0d:%08h",
                        instr_wr_addr, instr_wr_data, mon_wr.addr, mon_wr.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   function automatic logic [7:0] cs_of(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
      rx_data  = b;
      rx_valid = 1'b1;
      rx_error = err;
      tick();
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic start_burst(input logic [7:0] n);
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      send_byte(n);
   endtask

   task automatic send_instr(input logic [31:0] w, input logic [7:0] cs);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
      send_byte(cs);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      rx_valid     = 1'b0;
      rx_error     = 1'b0;
      stream_start = 1'b0;
      stream_abort = 1'b0;
      tx_ready     = 1'b1;
      repeat (2) tick();
      exp_rsp.delete();
      exp_wr.delete();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100 && (exp_rsp.size() != 0 || exp_wr.size() != 0); i++) tick();
      checks++;
      if (exp_rsp.size() != 0 || exp_wr.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got pending_rsp=%0d pending_wr=%0d required=0/0",
                  name, exp_rsp.size(), exp_wr.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({tx_valid, tx_data, instr_wr_en, instr_wr_addr, instr_wr_data, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got tv=%b td=%02h we=%b wa=%0d wd=%08h busy=%b done=%b required=all 0",
                  tx_valid, tx_data, instr_wr_en, instr_wr_addr, instr_wr_data, busy, done);
      end
      checks++;
      if (instr_count !== 0 || err_flags !== 4'h0 || state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got cnt=%0d err=%b st=%0d required=0/0000/0",
                  instr_count, err_flags, state_dbg);
      end
   endtask

   task automatic test_burst2();
      do_reset();
      exp_wr.push_back('{addr: 0, data: 32'hDEADBEEF});
      exp_wr.push_back('{addr: 1, data: 32'h01020304});
      exp_rsp.push_back(8'h00);
      exp_rsp.push_back(8'h00);
      exp_rsp.push_back(8'hA5);
      start_burst(8'd2);
      checks++;
      if (state_dbg !== 3'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL burst2_enter_data got st=%0d busy=%b required=2/1", state_dbg, busy);
      end
      send_instr(32'hDEADBEEF, 8'h22);
      checks++;
      if (instr_count !== 1 || done !== 1'b0) begin
         failures++;
         $display("FAIL burst2_mid got cnt=%0d done=%b required=1/0", instr_count, done);
      end
      send_instr(32'h01020304, 8'h04);
      checks++;
      if (done !== 1'b1 || instr_wr_en !== 1'b1 || instr_wr_addr !== 1) begin
         failures++;
         $display("FAIL burst2_done_pulse got done=%b we=%b wa=%0d required=1/1/1",
                  done, instr_wr_en, instr_wr_addr);
      end
      tick();
      checks++;
      if (done !== 1'b0 || instr_wr_en !== 1'b0 || state_dbg !== 3'd0 || instr_count !== 2) begin
         failures++;
         $display("FAIL burst2_after got done=%b we=%b st=%0d cnt=%0d required=0/0/0/2",
                  done, instr_wr_en, state_dbg, instr_count);
      end
      wait_drain("burst2");
   endtask

   task automatic test_csum_retry();
      int wr0;
      do_reset();
      wr0 = wr_cnt;
      exp_rsp.push_back(8'h01);
      exp_rsp.push_back(8'h00);
      exp_rsp.push_back(8'hA5);
      exp_wr.push_back('{addr: 0, data: 32'hDEADBEEF});
      start_burst(8'd1);
      send_instr(32'hDEADBEEF, 8'h00);
      checks++;
      if (state_dbg !== 3'd2 || instr_wr_en !== 1'b0 || instr_count !== 0) begin
         failures++;
         $display("FAIL retry_bad_cs got st=%0d we=%b cnt=%0d required=2/0/0",
                  state_dbg, instr_wr_en, instr_count);
      end
      send_instr(32'hDEADBEEF, 8'h22);
      wait_drain("retry");
      checks++;
      if (wr_cnt - wr0 !== 1 || instr_count !== 1) begin
         failures++;
         $display("FAIL retry_writes got writes=%0d cnt=%0d required=1/1", wr_cnt - wr0, instr_count);
      end
   endtask

   task automatic test_len_err();
      logic [7:0] lens[2];
      int wr0;
      lens[0] = 8'd0;
      lens[1] = 8'd33;
      for (int i = 0; i < 2; i++) begin
         do_reset();
         wr0 = wr_cnt;
         exp_rsp.push_back(8'hFF);
         start_burst(lens[i]);
         checks++;
         if (state_dbg !== 3'd0 || err_flags !== 4'b0001) begin
            failures++;
            $display("FAIL len_err_%0d got st=%0d err=%b required=0/0001", lens[i], state_dbg, err_flags);
         end
         wait_drain("len_err");
         checks++;
         if (wr_cnt != wr0) begin
            failures++;
            $display("FAIL len_err_nowrite got writes=%0d required=0", wr_cnt - wr0);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) exp_rsp.push_back(8'h00);
      exp_rsp.push_back(8'hA5);
      start_burst(8'd3);
      for (int i = 0; i < 3; i++) begin
         w = $urandom;
         exp_wr.push_back('{addr: AW'(i), data: w});
         send_instr(w, cs_of(w));
      end
      repeat (80) tick();
      checks++;
      if (tx_valid !== 1'b1 || err_flags[3] !== 1'b0 || exp_wr.size() != 0) begin
         failures++;
         $display("FAIL bp_hold got tv=%b ovr=%b pending_wr=%0d required=1/0/0",
                  tx_valid, err_flags[3], exp_wr.size());
      end
      tx_ready = 1'b1;
      wait_drain("bp");

      // Overfill: four OKs fill the queue and the trailing A5 is lost.
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) exp_rsp.push_back(8'h00);
      start_burst(8'd4);
      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         exp_wr.push_back('{addr: AW'(i), data: w});
         send_instr(w, cs_of(w));
      end
      repeat (3) tick();
      checks++;
      if (err_flags !== 4'b1000) begin
         failures++;
         $display("FAIL overfill_flag got err=%b required=1000", err_flags);
      end
      tx_ready = 1'b1;
      wait_drain("overfill");
      repeat (3) tick();
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL overfill_empty got tv=%b required=0", tx_valid);
      end
   endtask

   task automatic test_timeout();
      int k;
      int wr0;
      do_reset();
      wr0 = wr_cnt;
      start_burst(8'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      exp_rsp.push_back(8'hFE);
      k = 0;
      while (!tx_valid && k < TMO + 50) begin
         tick();
         k++;
      end
      checks++;
      if (k != TMO) begin
         failures++;
         $display("FAIL timeout_latency got=%0d cycles required=%0d", k, TMO);
      end
      checks++;
      if (err_flags !== 4'b0010 || state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL timeout_state got err=%b st=%0d required=0010/0", err_flags, state_dbg);
      end
      wait_drain("timeout");
      checks++;
      if (wr_cnt != wr0) begin
         failures++;
         $display("FAIL timeout_nowrite got writes=%0d required=0", wr_cnt - wr0);
      end
   endtask

   task automatic test_framing();
      do_reset();
      start_burst(8'd1);
      send_byte(8'h11);
      exp_rsp.push_back(8'hFD);
      send_byte(8'h22, 1'b1);
      checks++;
      if (err_flags !== 4'b0100 || state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL framing got err=%b st=%0d required=0100/0", err_flags, state_dbg);
      end
      wait_drain("framing");
   endtask

   task automatic test_abort_reset();
      logic [31:0] w;
      int wr0;
      do_reset();
      tx_ready = 1'b0;
      w = 32'hCAFE0001;
      exp_wr.push_back('{addr: 0, data: w});
      start_burst(8'd2);
      send_instr(w, cs_of(w));
      send_byte(8'h12);
      send_byte(8'h34);
      rst = 1'b1;
      tick();
      checks++;
      if (state_dbg !== 3'd0 || tx_valid !== 1'b0 || instr_wr_en !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_in_data got st=%0d tv=%b we=%b busy=%b required=0/0/0/0",
                  state_dbg, tx_valid, instr_wr_en, busy);
      end
      exp_rsp.delete();
      rst = 1'b0;
      tx_ready = 1'b1;
      tick();
      w = 32'h0BADF00D;
      exp_wr.push_back('{addr: 0, data: w});
      exp_rsp.push_back(8'h00);
      exp_rsp.push_back(8'hA5);
      start_burst(8'd1);
      send_instr(w, cs_of(w));
      wait_drain("after_rst");

      // Abort arrives together with a correct checksum byte and must win.
      wr0 = wr_cnt;
      w = 32'h55AA1234;
      start_burst(8'd1);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
      rx_data      = cs_of(w);
      rx_valid     = 1'b1;
      stream_abort = 1'b1;
      tick();
      rx_valid     = 1'b0;
      stream_abort = 1'b0;
      checks++;
      if (state_dbg !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_state got st=%0d busy=%b required=0/0", state_dbg, busy);
      end
      repeat (5) tick();
      checks++;
      if (tx_valid !== 1'b0 || wr_cnt != wr0) begin
         failures++;
         $display("FAIL abort_quiet got tv=%b writes=%0d required=0/0", tx_valid, wr_cnt - wr0);
      end
      w = 32'h76543210;
      exp_wr.push_back('{addr: 0, data: w});
      exp_rsp.push_back(8'h00);
      exp_rsp.push_back(8'hA5);
      start_burst(8'd1);
      send_instr(w, cs_of(w));
      wait_drain("after_abort");
      checks++;
      if (instr_count !== 1 || err_flags !== 4'h0) begin
         failures++;
         $display("FAIL after_abort_count got cnt=%0d err=%b required=1/0000", instr_count, err_flags);
      end
   endtask

   initial begin
      rst          = 1'b1;
      rx_data      = 8'h00;
      rx_valid     = 1'b0;
      rx_error     = 1'b0;
      tx_ready     = 1'b1;
      stream_start = 1'b0;
      stream_abort = 1'b0;
      test_reset();
      test_burst2();
      test_csum_retry();
      test_len_err();
      test_backpressure();
      test_timeout();
      test_framing();
      test_abort_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
